// File: rtl/maze_mem_arbiter.sv
// Two-requester arbiter (maze solver vs. host/loader) for a 1-bit-wide memory.
// Round-robin on contention, host burst lock that is broken after the solver waits WAITLIM cycles.
module maze_mem_arbiter #(
    parameter int WAITLIM = 16,
    parameter int AW      = 8
) (
    input  logic          clk,
    input  logic          rst,
    input  logic          sReq,
    input  logic          sWr,
    input  logic [AW-1:0] sLoc,
    input  logic          sDIn,
    output logic          sGnt,
    output logic          sVld,
    output logic          sDOut,
    input  logic          hReq,
    input  logic          hWr,
    input  logic [AW-1:0] hLoc,
    input  logic          hDIn,
    input  logic          hLock,
    output logic          hGnt,
    output logic          hVld,
    output logic          hDOut,
    output logic [AW-1:0] loc,
    output logic          dIn,
    output logic          rd,
    output logic          wr,
    input  logic          dOut,
    output logic          busy,
    output logic          lockBrk
);

    // state | meaning
    // IDLE  | no access this cycle
    // GNTS  | solver owns the memory this cycle
    // GNTH  | host owns the memory this cycle
    typedef enum logic [1:0] {IDLE = 2'd0, GNTS = 2'd1, GNTH = 2'd2} state_e;

    localparam logic [4:0] WAIT_MAX = 5'(WAITLIM);

    state_e     state_q, state_d;
    logic       last_h_q, last_h_d;
    logic [4:0] wait_q, wait_d;
    logic       s_vld_q, s_vld_d;
    logic       h_vld_q, h_vld_d;
    logic       lock_hold;
    logic       lock_brk;

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            state_q  <= IDLE;
            last_h_q <= 1'b1;
            wait_q   <= '0;
            s_vld_q  <= 1'b0;
            h_vld_q  <= 1'b0;
        end else begin
            state_q  <= state_d;
            last_h_q <= last_h_d;
            wait_q   <= wait_d;
            s_vld_q  <= s_vld_d;
            h_vld_q  <= h_vld_d;
        end
    end

    always_comb begin
        lock_hold = (state_q == GNTH) && hLock && hReq;
        lock_brk  = lock_hold && sReq && (wait_q == WAIT_MAX);

        state_d = IDLE;
        if (lock_brk) begin
            state_d = GNTS;
        end else if (lock_hold) begin
            state_d = GNTH;
        end else if (sReq && hReq) begin
            state_d = last_h_q ? GNTS : GNTH;
        end else if (sReq) begin
            state_d = GNTS;
        end else if (hReq) begin
            state_d = GNTH;
        end

        // last tracks the owner of the cycle being entered, so a tie is decided against it
        last_h_d = last_h_q;
        if (state_d == GNTS) begin
            last_h_d = 1'b0;
        end else if (state_d == GNTH) begin
            last_h_d = 1'b1;
        end

        wait_d = wait_q;
        if (state_q == GNTS) begin
            wait_d = '0;
        end else if (sReq && (wait_q < WAIT_MAX)) begin
            wait_d = wait_q + 5'd1;
        end

        s_vld_d = (state_q == GNTS) && !sWr;
        h_vld_d = (state_q == GNTH) && !hWr;
    end

    always_comb begin
        sGnt = 1'b0;
        hGnt = 1'b0;
        loc  = '0;
        dIn  = 1'b0;
        rd   = 1'b0;
        wr   = 1'b0;
        case (state_q)
            GNTS: begin
                sGnt = 1'b1;
                loc  = sLoc;
                dIn  = sDIn;
                rd   = ~sWr;
                wr   = sWr;
            end
            GNTH: begin
                hGnt = 1'b1;
                loc  = hLoc;
                dIn  = hDIn;
                rd   = ~hWr;
                wr   = hWr;
            end
            default: ;
        endcase
        busy    = (state_q != IDLE);
        lockBrk = lock_brk;
        sVld    = s_vld_q;
        hVld    = h_vld_q;
        sDOut   = s_vld_q & dOut;
        hDOut   = h_vld_q & dOut;
    end

endmodule

// File: tb/tb_maze_mem_arbiter.sv
// Bench for maze_mem_arbiter: directed scenarios followed by random traffic, all checked
// against a cycle-level ownership model and a shadow copy of memory contents.
module tb_maze_mem_arbiter;

    localparam int WAITLIM = 16;
    localparam int AW      = 8;

    logic          clk = 1'b0;
    logic          rst;
    logic          sReq, sWr, sDIn, sGnt, sVld, sDOut;
    logic [AW-1:0] sLoc;
    logic          hReq, hWr, hDIn, hLock, hGnt, hVld, hDOut;
    logic [AW-1:0] hLoc;
    logic [AW-1:0] loc;
    logic          dIn, rd, wr, dOut, busy, lockBrk;

    int checks   = 0;
    int failures = 0;

    // memory device seen by the DUT, and the bench's own record of what it should hold
    logic mem     [0:(1<<AW)-1];
    logic ref_mem [0:(1<<AW)-1];

    // ownership model: 0 = nobody, 1 = solver, 2 = host
    int   exp_gnt, prev_gnt, m_wait;
    logic m_last_h;
    logic ev_s, ev_h, ed_s, ed_h;

    logic          m_rd, m_wr, m_din;
    logic [AW-1:0] m_loc;

    int            n_gnt, n_brk, brk_cnt;
    logic [7:0]    pat;
    logic          orig7;

    maze_mem_arbiter #(.WAITLIM(WAITLIM), .AW(AW)) dut (
        .clk(clk), .rst(rst),
        .sReq(sReq), .sWr(sWr), .sLoc(sLoc), .sDIn(sDIn),
        .sGnt(sGnt), .sVld(sVld), .sDOut(sDOut),
        .hReq(hReq), .hWr(hWr), .hLoc(hLoc), .hDIn(hDIn), .hLock(hLock),
        .hGnt(hGnt), .hVld(hVld), .hDOut(hDOut),
        .loc(loc), .dIn(dIn), .rd(rd), .wr(wr), .dOut(dOut),
        .busy(busy), .lockBrk(lockBrk)
    );

    always #5 clk = ~clk;

    task automatic chk1(input string tag, input logic obs, input logic exp);
        checks++;
        assert (obs === exp) else begin
            failures++;
            $error("FAIL %s observed=%b expected=%b at %0t", tag, obs, exp, $time);
        end
    endtask

    task automatic chkw(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        checks++;
        assert (obs === exp) else begin
            failures++;
            $error("FAIL %s observed=%0d expected=%0d at %0t", tag, obs, exp, $time);
        end
    endtask

    // Called at posedge+1; checks the current cycle at negedge, then advances one clock.
    task automatic tick();
        logic [AW-1:0] e_loc;
        logic          e_din, e_rd, e_wr, e_brk;
        int            ng;
        @(negedge clk);
        e_loc = '0; e_din = 1'b0; e_rd = 1'b0; e_wr = 1'b0;
        if (exp_gnt == 1) begin
            e_loc = sLoc; e_din = sDIn; e_rd = ~sWr; e_wr = sWr;
        end else if (exp_gnt == 2) begin
            e_loc = hLoc; e_din = hDIn; e_rd = ~hWr; e_wr = hWr;
        end
        e_brk = (exp_gnt == 2) && hLock && hReq && sReq && (m_wait == WAITLIM);
        chk1("sGnt", sGnt, exp_gnt == 1);
        chk1("hGnt", hGnt, exp_gnt == 2);
        chk1("busy", busy, exp_gnt != 0);
        chk1("rd", rd, e_rd);
        chk1("wr", wr, e_wr);
        chkw("loc", 32'(loc), 32'(e_loc));
        chk1("dIn", dIn, e_din);
        chk1("lockBrk", lockBrk, e_brk);
        chk1("sVld", sVld, ev_s);
        chk1("hVld", hVld, ev_h);
        chk1("sDOut", sDOut, ev_s & ed_s);
        chk1("hDOut", hDOut, ev_h & ed_h);
        m_rd = rd; m_wr = wr; m_loc = loc; m_din = dIn;
        @(posedge clk);
        if (m_wr) mem[m_loc] = m_din;
        if (m_rd) dOut = mem[m_loc];
        ev_s = 1'b0; ev_h = 1'b0; ed_s = 1'b0; ed_h = 1'b0;
        if (exp_gnt == 1) begin
            if (sWr) ref_mem[sLoc] = sDIn;
            else begin ev_s = 1'b1; ed_s = ref_mem[sLoc]; end
        end else if (exp_gnt == 2) begin
            if (hWr) ref_mem[hLoc] = hDIn;
            else begin ev_h = 1'b1; ed_h = ref_mem[hLoc]; end
        end
        // who owns the memory next cycle
        if (exp_gnt == 2 && hLock && hReq && !(sReq && m_wait == WAITLIM)) ng = 2;
        else if (sReq && hReq) ng = m_last_h ? 1 : 2;
        else if (sReq) ng = 1;
        else if (hReq) ng = 2;
        else ng = 0;
        if (exp_gnt == 1) m_wait = 0;
        else if (sReq && m_wait < WAITLIM) m_wait = m_wait + 1;
        if (ng != 0) m_last_h = (ng == 2);
        prev_gnt = exp_gnt;
        exp_gnt  = ng;
        #1;
    endtask

    task automatic apply_reset();
        rst = 1'b1;
        sReq = 1'b0; hReq = 1'b0; hLock = 1'b0;
        #1;
        chk1("rst_rd", rd, 1'b0);
        chk1("rst_wr", wr, 1'b0);
        chk1("rst_sGnt", sGnt, 1'b0);
        chk1("rst_hGnt", hGnt, 1'b0);
        chk1("rst_busy", busy, 1'b0);
        chk1("rst_sVld", sVld, 1'b0);
        chk1("rst_hVld", hVld, 1'b0);
        chk1("rst_lockBrk", lockBrk, 1'b0);
        exp_gnt = 0; prev_gnt = 0; m_wait = 0; m_last_h = 1'b1;
        ev_s = 1'b0; ev_h = 1'b0; ed_s = 1'b0; ed_h = 1'b0;
        @(posedge clk);
        #1;
        rst = 1'b0;
    endtask

    initial begin
        rst = 1'b1; dOut = 1'b0;
        sReq = 1'b0; sWr = 1'b0; sLoc = '0; sDIn = 1'b0;
        hReq = 1'b0; hWr = 1'b0; hLoc = '0; hDIn = 1'b0; hLock = 1'b0;
        for (int i = 0; i < (1 << AW); i++) begin
            mem[i]     = 1'($urandom);
            ref_mem[i] = mem[i];
        end
        apply_reset();

        // no request after reset release: no grant
        tick();
        chk1("post_rst_idle", busy, 1'b0);

        // single solver read of a known 1
        mem[8'h15] = 1'b1; ref_mem[8'h15] = 1'b1;
        sReq = 1'b1; sWr = 1'b0; sLoc = 8'h15; sDIn = 1'b0;
        tick();
        #1;
        chk1("rd1_sGnt", sGnt, 1'b1);
        chk1("rd1_rd", rd, 1'b1);
        chkw("rd1_loc", 32'(loc), 32'h15);
        sReq = 1'b0;
        tick();
        #1;
        chk1("rd1_sVld", sVld, 1'b1);
        chk1("rd1_sDOut", sDOut, 1'b1);
        tick();

        // locked host burst writing 0..7, then solver readback
        pat = 8'($urandom);
        hReq = 1'b1; hLock = 1'b1; hWr = 1'b1; hLoc = 8'd0; hDIn = pat[0];
        tick();
        for (int i = 0; i < 8; i++) begin
            #1;
            chk1("burst_hGnt", hGnt, 1'b1);
            chk1("burst_wr", wr, 1'b1);
            chkw("burst_loc", 32'(loc), 32'(i));
            if (i == 7) begin hReq = 1'b0; hLock = 1'b0; end
            tick();
            if (i < 7) begin hLoc = 8'(i + 1); hDIn = pat[i+1]; end
        end
        for (int i = 0; i < 8; i++) begin
            sReq = 1'b1; sWr = 1'b0; sLoc = 8'(i);
            tick();
            sReq = 1'b0;
            tick();
            #1;
            chk1("burst_readback", sDOut, pat[i]);
        end
        tick();

        // tie after reset alternates starting with the solver
        apply_reset();
        sReq = 1'b1; hReq = 1'b1; sWr = 1'b0; hWr = 1'b0; sLoc = 8'd1; hLoc = 8'd2;
        tick();
        for (int i = 0; i < 4; i++) begin
            #1;
            chk1("tie_sGnt", sGnt, (i % 2) == 0);
            chk1("tie_hGnt", hGnt, (i % 2) == 1);
            tick();
        end
        sReq = 1'b0; hReq = 1'b0;
        tick();

        // starvation break of a host lock
        hReq = 1'b1; hLock = 1'b1; hWr = 1'b0; hLoc = 8'd3;
        tick();
        sReq = 1'b1; sWr = 1'b0; sLoc = 8'd4;
        n_gnt = -1; n_brk = -1; brk_cnt = 0;
        for (int n = 0; n < 40 && n_gnt < 0; n++) begin
            #1;
            if (lockBrk) begin
                brk_cnt++;
                if (n_brk < 0) n_brk = n;
            end
            if (sGnt) begin
                n_gnt = n;
                sReq = 1'b0;
            end
            tick();
        end
        chkw("starve_gnt_cycle", 32'(n_gnt), 32'(WAITLIM + 1));
        chkw("starve_brk_cycle", 32'(n_brk), 32'(WAITLIM));
        chkw("starve_brk_count", 32'(brk_cnt), 32'd1);
        #1;
        chk1("relock_hGnt", hGnt, 1'b1);
        tick();
        #1;
        chk1("relock_held", hGnt, 1'b1);
        hReq = 1'b0; hLock = 1'b0;
        tick();
        tick();

        // reset in the middle of a solver read
        sReq = 1'b1; sWr = 1'b0; sLoc = 8'd5;
        tick();
        #1;
        chk1("midrd_sGnt", sGnt, 1'b1);
        #2;
        apply_reset();
        tick();
        #1;
        chk1("midrd_no_vld", sVld, 1'b0);
        tick();
        sReq = 1'b1; hReq = 1'b1; sWr = 1'b0; hWr = 1'b0; sLoc = 8'd1; hLoc = 8'd2;
        tick();
        #1;
        chk1("midrd_tie_s_first", sGnt, 1'b1);
        sReq = 1'b0;
        tick();
        #1;
        chk1("midrd_tie_h_next", hGnt, 1'b1);
        hReq = 1'b0;
        tick();

        // host request withdrawn while the solver holds back-to-back grants
        orig7 = ref_mem[7];
        sReq = 1'b1; sWr = 1'b0; sLoc = 8'd6;
        tick();
        hReq = 1'b1; hWr = 1'b1; hLoc = 8'd7; hDIn = ~orig7;
        #2;
        chk1("wd_no_hGnt", hGnt, 1'b0);
        hReq = 1'b0;
        tick();
        #1;
        chk1("wd_s_b2b", sGnt, 1'b1);
        sReq = 1'b0;
        tick();
        #1;
        chk1("wd_hVld", hVld, 1'b0);
        sReq = 1'b1; sLoc = 8'd7;
        tick();
        sReq = 1'b0;
        tick();
        #1;
        chk1("wd_mem_kept", sDOut, orig7);
        tick();

        // random traffic against the model
        for (int c = 0; c < 3000; c++) begin
            if (c == 1500) apply_reset();
            if (prev_gnt == 1 || !sReq) begin
                sWr = 1'($urandom); sLoc = 8'($urandom_range(0, 15)); sDIn = 1'($urandom);
            end
            if (exp_gnt == 1 || !sReq) sReq = ($urandom_range(0, 3) != 0);
            else if ($urandom_range(0, 15) == 0) sReq = 1'b0;
            if (prev_gnt == 2 || !hReq) begin
                hWr = 1'($urandom); hLoc = 8'($urandom_range(0, 15)); hDIn = 1'($urandom);
            end
            if (exp_gnt == 2 || !hReq) hReq = ($urandom_range(0, 3) != 0);
            else if ($urandom_range(0, 15) == 0) hReq = 1'b0;
            if ($urandom_range(0, 19) == 0) hLock = ~hLock;
            tick();
        end

        $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
        $finish;
    end

endmodule
